decade_timer_ctrl: RTL

Controller that sequences a chain of cascaded decade (0-9) digit stages as a programmable BCD up-timer. It accepts START/STOP/CLEAR commands over a valid/ready handshake and generates the tick enable from a clock prescaler. It ripples carries between digits and stops at a programmed BCD limit with a one-cycle done pulse. It sits between the system command logic and the display/decode path.

---
 rtl/decade_timer_pkg.sv | 25 ++
 rtl/decade_timer_ctrl_bcd_digit.sv | 36 +++
 rtl/decade_timer_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/decade_timer_pkg.sv
// +--------------------------------------------------------------------+
// | decade_timer_pkg : shared types and constants for the decade timer |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package decade_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

`default_nettype wire

// File: rtl/decade_timer_ctrl_bcd_digit.sv
// +--------------------------------------------------------------------+
// | bcd_digit : one decade (0-9) counter stage with ripple carry out    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module bcd_digit
  import decade_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] r_digit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digit <= 4'd0;
    end else if (clr) begin
      r_digit <= 4'd0;
    end else if (inc) begin
      // >= rather than == keeps the stage self-correcting should it ever upset
      r_digit <= (r_digit >= BCD_MAX) ? 4'd0 : r_digit + 4'd1;
    end
  end

  assign digit = r_digit;
  assign carry = inc && (r_digit == BCD_MAX);

endmodule

`default_nettype wire

// File: rtl/decade_timer_ctrl.sv
// +--------------------------------------------------------------------+
// | decade_timer_ctrl : command-driven BCD up-timer with prescaled tick |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module decade_timer_ctrl
  import decade_timer_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [4*DIGITS-1:0]   limit_bcd,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  running,
  output logic                  done,
  output logic                  err
);

  localparam int c_count_w = 4 * DIGITS;
  localparam int c_pre_w   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_pre_w-1:0]   r_pre;
  logic [c_pre_w-1:0]   w_pre_nxt;
  logic [c_count_w-1:0] r_limit;
  logic [c_count_w-1:0] w_count;
  logic [c_count_w-1:0] w_count_inc;
  logic [DIGITS:0]      w_inc;
  logic                 r_cmd_ready;
  logic                 r_done;
  logic                 r_err;
  logic                 w_accept;
  logic                 w_start;
  logic                 w_stop;
  logic                 w_clear;
  logic                 w_cmd;
  logic                 w_limit_ok;
  logic                 w_tick;
  logic                 w_latch;
  logic                 w_done_nxt;
  logic                 w_err_nxt;

  assign w_accept = cmd_valid && r_cmd_ready;
  assign w_start  = w_accept && (cmd_op == OP_START);
  assign w_stop   = w_accept && (cmd_op == OP_STOP);
  assign w_clear  = w_accept && (cmd_op == OP_CLEAR);
  assign w_cmd    = w_start || w_stop || w_clear;

  // An accepted command owns the cycle, so it pre-empts a coincident tick
  assign w_tick = (r_state == RUN) && (r_pre == c_pre_last) && !w_cmd;

  always_comb begin
    w_limit_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (limit_bcd[4*k +: 4] > BCD_MAX) begin
        w_limit_ok = 1'b0;
      end
    end
  end

  assign w_inc[0] = w_tick;

  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      bcd_digit u_digit (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_clear),
        .inc     (w_inc[k]),
        .digit   (w_count[4*k +: 4]),
        .carry   (w_inc[k+1])
      );

      // Post-increment view of this digit, used by the terminal-count compare
      assign w_count_inc[4*k +: 4] = w_inc[k+1] ? 4'd0 :
                                     w_inc[k]   ? w_count[4*k +: 4] + 4'd1 :
                                                  w_count[4*k +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_latch     = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_clear) begin
      w_state_nxt = IDLE;
      w_pre_nxt   = '0;
    end else if (w_start) begin
      if (!w_limit_ok) begin
        w_err_nxt = 1'b1;
      end else begin
        w_latch   = 1'b1;
        w_pre_nxt = '0;
        if (limit_bcd == w_count) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = RUN;
        end
      end
    end else if (w_stop) begin
      if (r_state == RUN) begin
        w_state_nxt = PAUSE;
      end
    end else if (r_state == RUN) begin
      if (w_tick) begin
        w_pre_nxt = '0;
        if (w_count_inc == r_limit) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
        end
      end else begin
        w_pre_nxt = r_pre + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre       <= '0;
      r_limit     <= '0;
      r_cmd_ready <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_pre       <= w_pre_nxt;
      r_cmd_ready <= !w_cmd;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      if (w_latch) begin
        r_limit <= limit_bcd;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign count_bcd = w_count;
  assign running   = (r_state == RUN);
  assign done      = r_done;
  assign err       = r_err;

endmodule

`default_nettype wire
